// File: rtl/mb_ascii_tx.sv
// Modbus ASCII slave transmitter: PDU byte stream in, ':' addr PDU LRC CR LF out as ASCII hex.
// Latency: in_valid in IDLE -> ':' on tx_data next cycle; PDU byte accept -> hi nibble next cycle.
// Backpressure: tx_valid/tx_data hold until tx_ready; in_ready only while waiting for the next PDU byte.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_data/in_valid/in_last   PDU byte stream, in_ready accepts a byte
//   tx_data/tx_valid/tx_ready  ASCII character stream to the UART
//   busy                       frame in progress
//   tx_done                    1-cycle pulse after the final LF is taken by the UART
//   err_overflow               sticky: PDU longer than MaxPdu, cleared at next frame start
module mb_ascii_tx #(
   parameter logic [7:0] SlaveAddress = 8'h0A,
   parameter int         MaxPdu       = 253
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       err_overflow
);

   typedef enum logic [3:0] {
      IDLE, SOF, ADR_HI, ADR_LO, LOAD, D_HI, D_LO, LRC_HI, LRC_LO, CR, LF
   } state_t;

   localparam logic [7:0] MAX_B = 8'(MaxPdu);

   state_t     state;
   logic [7:0] sum;       // wrapping sum of address + kept PDU bytes
   logic [7:0] count;     // PDU bytes accepted, saturates at MaxPdu+1
   logic [3:0] lo_q;      // low nibble of the latched byte; high nibble goes out directly
   logic       last_q;
   logic [7:0] lrc;
   logic       hs;

   // Uppercase ASCII hex digit for one nibble.
   function automatic logic [7:0] hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   assign lrc      = 8'(~sum + 8'd1);
   assign hs       = tx_valid & tx_ready;
   assign in_ready = (state == LOAD);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         tx_data      <= 8'h00;
         tx_valid     <= 1'b0;
         tx_done      <= 1'b0;
         err_overflow <= 1'b0;
         sum          <= 8'h00;
         count        <= 8'h00;
         lo_q         <= 4'h0;
         last_q       <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               // Start of frame only; the PDU byte itself is taken later in LOAD.
               if (in_valid) begin
                  state        <= SOF;
                  sum          <= 8'h00;
                  count        <= 8'h00;
                  err_overflow <= 1'b0;
                  tx_valid     <= 1'b1;
                  tx_data      <= 8'h3A;
               end
            end
            SOF: if (hs) begin
               state   <= ADR_HI;
               tx_data <= hex(SlaveAddress[7:4]);
            end
            ADR_HI: if (hs) begin
               state   <= ADR_LO;
               tx_data <= hex(SlaveAddress[3:0]);
            end
            ADR_LO: if (hs) begin
               state    <= LOAD;
               tx_valid <= 1'b0;
               sum      <= sum + SlaveAddress;
            end
            LOAD: begin
               if (in_valid) begin
                  if (count < MAX_B) begin
                     lo_q     <= in_data[3:0];
                     last_q   <= in_last;
                     sum      <= sum + in_data;
                     count    <= count + 8'd1;
                     state    <= D_HI;
                     tx_valid <= 1'b1;
                     tx_data  <= hex(in_data[7:4]);
                  end else begin
                     // Excess byte: swallowed, frame closes on in_last over the kept bytes.
                     err_overflow <= 1'b1;
                     count        <= MAX_B + 8'd1;
                     if (in_last) begin
                        state    <= LRC_HI;
                        tx_valid <= 1'b1;
                        tx_data  <= hex(lrc[7:4]);
                     end
                  end
               end
            end
            D_HI: if (hs) begin
               state   <= D_LO;
               tx_data <= hex(lo_q);
            end
            D_LO: if (hs) begin
               if (last_q) begin
                  state   <= LRC_HI;
                  tx_data <= hex(lrc[7:4]);
               end else begin
                  state    <= LOAD;
                  tx_valid <= 1'b0;
               end
            end
            LRC_HI: if (hs) begin
               state   <= LRC_LO;
               tx_data <= hex(lrc[3:0]);
            end
            LRC_LO: if (hs) begin
               state   <= CR;
               tx_data <= 8'h0D;
            end
            CR: if (hs) begin
               state   <= LF;
               tx_data <= 8'h0A;
            end
            LF: if (hs) begin
               state    <= IDLE;
               tx_valid <= 1'b0;
               tx_done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mb_ascii_tx.sv
module tb_mb_ascii_tx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       tx_ready = 1'b0;
   logic       sel4 = 1'b0;   // 1: traffic goes to the MaxPdu=4 instance

   logic       in_ready_a, tx_valid_a, busy_a, tx_done_a, err_a;
   logic       in_ready_b, tx_valid_b, busy_b, tx_done_b, err_b;
   logic [7:0] tx_data_a, tx_data_b;

   mb_ascii_tx dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid & ~sel4), .in_last(in_last), .in_ready(in_ready_a),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready & ~sel4),
      .busy(busy_a), .tx_done(tx_done_a), .err_overflow(err_a)
   );

   mb_ascii_tx #(.SlaveAddress(8'h0A), .MaxPdu(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid & sel4), .in_last(in_last), .in_ready(in_ready_b),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready & sel4),
      .busy(busy_b), .tx_done(tx_done_b), .err_overflow(err_b)
   );

   logic       in_ready, tx_valid, busy, tx_done, err_overflow;
   logic [7:0] tx_data;
   assign in_ready     = sel4 ? in_ready_b : in_ready_a;
   assign tx_valid     = sel4 ? tx_valid_b : tx_valid_a;
   assign tx_data      = sel4 ? tx_data_b  : tx_data_a;
   assign busy         = sel4 ? busy_b     : busy_a;
   assign tx_done      = sel4 ? tx_done_b  : tx_done_a;
   assign err_overflow = sel4 ? err_b      : err_a;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Reference model: the whole ADU of a PDU as a character list.
   logic [7:0] pdu[$];
   logic [8:0] exp_q[$];   // bit 8 marks the closing LF of a frame
   logic [7:0] got_q[$];
   string      hx = "0123456789ABCDEF";

   task automatic push_char(input logic [7:0] c, input logic eof);
      exp_q.push_back({eof, c});
   endtask

   task automatic push_model(input int maxp);
      int n;
      int s;
      int lrc;
      n = (pdu.size() < maxp) ? pdu.size() : maxp;
      s = 'h0A;
      push_char(8'h3A, 1'b0);
      push_char(hx[0], 1'b0);
      push_char(hx[10], 1'b0);
      for (int i = 0; i < n; i++) begin
         s = s + int'(pdu[i]);
         push_char(hx[int'(pdu[i]) / 16], 1'b0);
         push_char(hx[int'(pdu[i]) % 16], 1'b0);
      end
      lrc = (256 - (s % 256)) % 256;
      push_char(hx[lrc / 16], 1'b0);
      push_char(hx[lrc % 16], 1'b0);
      push_char(8'h0D, 1'b0);
      push_char(8'h0A, 1'b1);
   endtask

   // UART side: always ready, or a coin flip per cycle.
   bit rand_ready = 1'b0;
   always @(posedge clk) begin
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Cycle-by-cycle output checker.
   bit         ignore = 1'b0;
   bit         done_exp = 1'b0;
   int         n_acc = 0;
   int         b2b_hits = 0;
   logic       prev_v = 1'b0, prev_r = 1'b0, prev_done = 1'b0, prev_inv = 1'b0;
   logic [7:0] prev_d = 8'h00;

   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst_n) begin
         prev_v = 1'b0; prev_done = 1'b0; done_exp = 1'b0;
      end else begin
         if (!ignore) begin
            check("tx_done", {31'd0, tx_done}, {31'd0, done_exp});
            done_exp = 1'b0;
            if (prev_v && !prev_r) begin
               check("hold_valid", {31'd0, tx_valid}, 32'd1);
               check("hold_data", {24'd0, tx_data}, {24'd0, prev_d});
            end
            if (prev_done && prev_inv) begin
               b2b_hits++;
               check("b2b_valid", {31'd0, tx_valid}, 32'd1);
               check("b2b_sof", {24'd0, tx_data}, 32'h3A);
            end
            if (in_ready)
               check("in_ready_outside_load", {30'd0, busy, tx_valid}, 32'd2);
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_char: got %0h want none", tx_data);
               end else begin
                  e = exp_q.pop_front();
                  check("char", {24'd0, tx_data}, {24'd0, e[7:0]});
                  done_exp = e[8];
               end
               got_q.push_back(tx_data);
            end
         end else begin
            done_exp = 1'b0;
         end
         if (tx_valid && tx_ready) n_acc++;
         prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
         prev_done = tx_done; prev_inv = in_valid;
      end
   end

   task automatic send_pdu(input int maxp, input int gap_max);
      bit acc;
      for (int i = 0; i < pdu.size(); i++) begin
         acc = 1'b0;
         in_data  = pdu[i];
         in_last  = (i == pdu.size() - 1);
         in_valid = 1'b1;
         for (int t = 0; t < 6000 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
         end
         if (!acc) begin
            total++; bad++;
            $display("FAIL in_accept_timeout: byte %0d never accepted", i);
            in_valid = 1'b0;
            return;
         end
         check("err_overflow", {31'd0, err_overflow}, ((i + 1) > maxp) ? 32'd1 : 32'd0);
         if (gap_max > 0 && !in_last) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      for (t = 0; t < 20000 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
      if (exp_q.size() != 0 || busy) begin
         total++; bad++;
         $display("FAIL frame_timeout: %0d chars still expected", exp_q.size());
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic compare_got(input string s);
      check("frame_len", got_q.size(), s.len());
      for (int i = 0; i < s.len() && i < got_q.size(); i++)
         check("frame_char", {24'd0, got_q[i]}, {24'd0, s[i]});
      got_q.delete();
   endtask

   initial begin
      string f1, f2, f4;
      int len;
      f1 = ":0A0300000001F2\r\n";
      f2 = ":0A8373\r\n";
      f4 = ":0A01020304EC\r\n";

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_tx_done", {31'd0, tx_done}, 32'd0);
      check("rst_err", {31'd0, err_overflow}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Read-holding-registers response
      pdu = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
      push_model(253); send_pdu(253, 0); wait_done(); compare_got(f1);

      // Single-byte PDU
      pdu = '{8'h83};
      push_model(253); send_pdu(253, 0); wait_done(); compare_got(f2);

      // Same frame under random UART backpressure
      rand_ready = 1'b1;
      pdu = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
      push_model(253); send_pdu(253, 2); wait_done(); compare_got(f1);
      rand_ready = 1'b0;

      // Overflow on the MaxPdu=4 instance
      sel4 = 1'b1;
      @(posedge clk); #1;
      pdu = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      push_model(4); send_pdu(4, 0); wait_done(); compare_got(f4);
      check("err_sticky", {31'd0, err_overflow}, 32'd1);
      pdu = '{8'h55};
      push_model(4); send_pdu(4, 0); wait_done(); got_q.delete();
      check("err_cleared", {31'd0, err_overflow}, 32'd0);
      sel4 = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of a frame
      ignore = 1'b1;
      n_acc = 0;
      in_data = 8'h03; in_last = 1'b0; in_valid = 1'b1;
      for (int t = 0; t < 200 && n_acc < 5; t++) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("midrst_tx_data", {24'd0, tx_data}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_tx_done", {31'd0, tx_done}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      exp_q.delete(); got_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      ignore = 1'b0;
      @(posedge clk); #1;
      pdu = '{8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
      push_model(253); send_pdu(253, 0); wait_done();
      compare_got(":0A0600010003EC\r\n");

      // Back-to-back frames with in_valid held
      b2b_hits = 0;
      pdu = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
      push_model(253); send_pdu(253, 0);
      pdu = '{8'h83};
      push_model(253); send_pdu(253, 0);
      wait_done();
      compare_got({f1, f2});
      check("b2b_seen", (b2b_hits > 0) ? 32'd1 : 32'd0, 32'd1);

      // Random frames, random gaps and backpressure, one oversized frame
      rand_ready = 1'b1;
      for (int k = 0; k < 24; k++) begin
         len = (k == 11) ? 258 : int'($urandom_range(1, 10));
         pdu.delete();
         for (int i = 0; i < len; i++) pdu.push_back(8'($urandom_range(0, 255)));
         push_model(253);
         send_pdu(253, ($urandom_range(0, 1) == 1) ? 3 : 0);
         if ($urandom_range(0, 2) == 0) wait_done();
      end
      wait_done();
      got_q.delete();
      rand_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
